// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: FSM state encodings,
// opcode values and the decoded opcode-class bundle.
package cpu_ctrl_pkg;

   localparam int OPCODE_W_DEF = 4;
   localparam int TIMEOUT_DEF  = 16;
   localparam int STATE_W_DEF  = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXECUTE = 3'd3,
      S_MEM     = 3'd4,
      S_WB      = 3'd5,
      S_HALT    = 3'd6
   } state_t;

   localparam int OP_ALU_FIRST = 1;
   localparam int OP_ALU_LAST  = 7;
   localparam int OP_LOAD      = 8;
   localparam int OP_STORE     = 9;
   localparam int OP_JUMP      = 10;
   localparam int OP_HALT      = 15;

   typedef struct packed {
      logic is_nop;
      logic is_alu;
      logic is_load;
      logic is_store;
      logic is_jump;
      logic is_halt;
   } op_class_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Control/strobe bundle between the instruction sequencer and the datapath.
// The sequencer takes the slave side; the datapath/bench takes the master side.
interface instr_sequencer_if
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int STATE_W  = STATE_W_DEF
);
   logic                start;
   logic                halt_req;
   logic                step_mode;
   logic [OPCODE_W-1:0] opcode;
   logic                mem_ready;

   logic                mem_req;
   logic                mem_we;
   logic                ir_load;
   logic                pc_inc;
   logic                pc_load;
   logic                alu_en;
   logic                reg_we;
   logic                update_count;
   logic                running;
   logic                halted;
   logic                fault;
   logic [STATE_W-1:0]  state_out;

   modport master (
      output start, halt_req, step_mode, opcode, mem_ready,
      input  mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we,
      input  update_count, running, halted, fault, state_out
   );

   modport slave (
      input  start, halt_req, step_mode, opcode, mem_ready,
      output mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, reg_we,
      output update_count, running, halted, fault, state_out
   );

endinterface

// File: rtl/instr_sequencer_decode.sv
// Combinational opcode classifier; any opcode outside the defined classes
// falls into the NOP class.
module opcode_class_decode
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF
) (
   input  logic [OPCODE_W-1:0] opcode,
   output op_class_t           op_class
);

   logic is_alu;
   logic is_load;
   logic is_store;
   logic is_jump;
   logic is_halt;

   assign is_alu   = (opcode >= OPCODE_W'(OP_ALU_FIRST)) && (opcode <= OPCODE_W'(OP_ALU_LAST));
   assign is_load  = (opcode == OPCODE_W'(OP_LOAD));
   assign is_store = (opcode == OPCODE_W'(OP_STORE));
   assign is_jump  = (opcode == OPCODE_W'(OP_JUMP));
   assign is_halt  = (opcode == OPCODE_W'(OP_HALT));

   assign op_class = {!(is_alu || is_load || is_store || is_jump || is_halt),
                      is_alu, is_load, is_store, is_jump, is_halt};

endmodule

// File: rtl/instruction_count_register.sv
// Retired-instruction counter, advanced by one on each update_count pulse.
module instruction_count_register #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               update_count,
   output logic [COUNT_W-1:0] count_out
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_out <= '0;
      end else if (update_count) begin
         count_out <= count_out + COUNT_W'(1);
      end
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with run/halt/
// single-step control and a memory-wait timeout that forces HALT with a fault.
module instr_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF,
   parameter int STATE_W  = STATE_W_DEF
) (
   input logic              clk,
   input logic              rst,
   instr_sequencer_if.slave bus
);

   localparam int                CNT_W     = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_next;
   state_t           retire_target;
   logic             halt_pend;
   logic             fault_q;
   logic [CNT_W-1:0] wait_cnt;
   op_class_t        cls;
   logic             mem_phase;
   logic             timeout_hit;
   logic             retire;
   logic             run_state;

   opcode_class_decode #(.OPCODE_W(OPCODE_W)) u_decode (
      .opcode   (bus.opcode),
      .op_class (cls)
   );

   assign mem_phase     = (state == S_FETCH) || (state == S_MEM);
   assign timeout_hit   = mem_phase && !bus.mem_ready && (wait_cnt == WAIT_LAST);
   assign run_state     = (state != S_IDLE) && (state != S_HALT);
   assign retire_target = (halt_pend || bus.halt_req) ? S_HALT :
                          (bus.step_mode ? S_IDLE : S_FETCH);

   // Strobes and next state are decoded from the current state, the opcode
   // class and mem_ready; retire marks the last cycle of an instruction.
   always_comb begin
      bus.mem_req = mem_phase;
      bus.mem_we  = 1'b0;
      bus.ir_load = 1'b0;
      bus.pc_inc  = 1'b0;
      bus.pc_load = 1'b0;
      bus.alu_en  = 1'b0;
      bus.reg_we  = 1'b0;
      retire      = 1'b0;
      state_next  = state;
      case (state)
         S_IDLE: begin
            if (bus.halt_req) begin
               state_next = S_HALT;
            end else if (bus.start) begin
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (bus.mem_ready) begin
               bus.ir_load = 1'b1;
               bus.pc_inc  = 1'b1;
               state_next  = S_DECODE;
            end else if (timeout_hit) begin
               state_next = S_HALT;
            end
         end
         S_DECODE: begin
            if (cls.is_halt) begin
               state_next = S_HALT;
            end else if (cls.is_nop) begin
               retire     = 1'b1;
               state_next = retire_target;
            end else begin
               state_next = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            bus.alu_en  = cls.is_alu;
            bus.pc_load = cls.is_jump;
            if (cls.is_alu) begin
               state_next = S_WB;
            end else if (cls.is_load || cls.is_store) begin
               state_next = S_MEM;
            end else begin
               retire     = 1'b1;
               state_next = retire_target;
            end
         end
         S_MEM: begin
            bus.mem_we = cls.is_store;
            if (bus.mem_ready) begin
               if (cls.is_store) begin
                  retire     = 1'b1;
                  state_next = retire_target;
               end else begin
                  state_next = S_WB;
               end
            end else if (timeout_hit) begin
               state_next = S_HALT;
            end
         end
         S_WB: begin
            bus.reg_we = 1'b1;
            retire     = 1'b1;
            state_next = retire_target;
         end
         S_HALT: begin
            if (bus.start && !bus.halt_req) begin
               state_next = S_FETCH;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // A HALT opcode counts as retired in DECODE even though it bypasses retire.
   assign bus.update_count = retire || ((state == S_DECODE) && cls.is_halt);
   assign bus.running      = run_state;
   assign bus.halted       = (state == S_HALT);
   assign bus.fault        = fault_q;
   assign bus.state_out    = STATE_W'(state);

   // wait_cnt only survives while a memory phase keeps stalling, so every
   // entry into FETCH/MEM sees it at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         halt_pend <= 1'b0;
         fault_q   <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         state <= state_next;
         if (mem_phase && !bus.mem_ready && !timeout_hit) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (state_next == S_HALT) begin
            halt_pend <= 1'b0;
         end else if (run_state && bus.halt_req) begin
            halt_pend <= 1'b1;
         end
         if (timeout_hit) begin
            fault_q <= 1'b1;
         end else if ((state == S_HALT) && (state_next == S_FETCH)) begin
            fault_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer plus instruction_count_register: a per-instruction
// phase-plan model checked every cycle, and hand-computed literal checkpoints.
module tb_instr_sequencer;

   localparam int OPCODE_W = 4;
   localparam int STATE_W  = 3;
   localparam int TIMEOUT  = 16;
   localparam int COUNT_W  = 16;

   localparam int PH_FETCH = 1, PH_DEC = 2, PH_EXE = 3, PH_MEM = 4, PH_WB = 5;
   localparam int WH_IDLE = 0, WH_RUN = 1, WH_HALT = 2;
   localparam int C_NOP = 0, C_ALU = 1, C_LOAD = 2, C_STORE = 3, C_JUMP = 4, C_HALT = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic                count_rst;
   logic                mem_rewind;
   logic [COUNT_W-1:0]  count_out;
   logic [OPCODE_W-1:0] ir = '0;
   logic [OPCODE_W-1:0] prog [16];
   int                  pc = 0;
   logic [13:0]         out_vec;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int reg_we_pulses = 0;
   int rw_base;

   int  m_where = WH_IDLE;
   int  m_plan[$];
   int  m_wait = 0;
   bit  m_pend = 1'b0;
   bit  m_fault = 1'b0;
   int  m_count = 0;

   instr_sequencer_if #(.OPCODE_W(OPCODE_W), .STATE_W(STATE_W)) bus ();

   instr_sequencer #(.OPCODE_W(OPCODE_W), .TIMEOUT(TIMEOUT), .STATE_W(STATE_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   instruction_count_register #(.COUNT_W(COUNT_W)) u_count (
      .clk          (clk),
      .rst          (count_rst),
      .update_count (bus.update_count),
      .count_out    (count_out)
   );

   always #5 clk = ~clk;

   assign bus.opcode = ir;
   assign out_vec = {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_inc, bus.pc_load,
                     bus.alu_en, bus.reg_we, bus.update_count, bus.running,
                     bus.halted, bus.fault, bus.state_out};

   // Instruction memory: IR is captured from the program when the sequencer loads it.
   always @(posedge clk) begin
      if (mem_rewind) begin
         pc <= 0;
      end else if (bus.ir_load) begin
         ir <= prog[pc % 16];
         pc <= pc + 1;
      end
   end

   function automatic int op_class(input logic [3:0] op);
      if (op >= 4'h1 && op <= 4'h7) return C_ALU;
      case (op)
         4'h8:    return C_LOAD;
         4'h9:    return C_STORE;
         4'hA:    return C_JUMP;
         4'hF:    return C_HALT;
         default: return C_NOP;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: actual %0h required %0h",
                  name, cycle, actual, required);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic halt_req,
                                input logic step_mode, input logic mem_ready);
      bus.start     = start;
      bus.halt_req  = halt_req;
      bus.step_mode = step_mode;
      bus.mem_ready = mem_ready;
   endtask

   task automatic clearCounterAndProgram();
      count_rst  = 1'b1;
      mem_rewind = 1'b1;
      for (int i = 0; i < 16; i++) prog[i] = 4'h0;
      tick(1);
      count_rst  = 1'b0;
      mem_rewind = 1'b0;
   endtask

   // Model: each instruction is a plan of phases built at decode; outputs are
   // derived from the current phase, the opcode class and the inputs.
   always @(negedge clk) begin : model_cmp
      int cur;
      int cls;
      bit e_mreq, e_mwe, e_irl, e_pcl, e_alu, e_rwe, e_upd, e_run, e_hlt, e_flt;
      bit mem_ph, step_done, tmo, to_halt;
      int e_st;
      logic [13:0] exp_v;
      cycle++;
      {e_mreq, e_mwe, e_irl, e_pcl, e_alu, e_rwe, e_upd, e_run, e_hlt} = '0;
      e_st    = 0;
      to_halt = 1'b0;
      e_flt   = m_fault;
      if (rst) begin
         m_where = WH_IDLE;
         m_pend  = 1'b0;
         m_fault = 1'b0;
         m_wait  = 0;
         e_flt   = 1'b0;
      end else begin
         case (m_where)
            WH_IDLE: begin
               if (bus.halt_req) begin
                  m_where = WH_HALT;
               end else if (bus.start) begin
                  m_where = WH_RUN;
                  m_plan  = '{PH_FETCH, PH_DEC};
                  m_wait  = 0;
               end
            end
            WH_HALT: begin
               e_hlt = 1'b1;
               e_st  = 6;
               if (bus.start && !bus.halt_req) begin
                  m_where = WH_RUN;
                  m_plan  = '{PH_FETCH, PH_DEC};
                  m_wait  = 0;
                  m_fault = 1'b0;
               end
            end
            default: begin
               e_run = 1'b1;
               cls = op_class(bus.opcode);
               if (m_plan[0] == PH_DEC) begin
                  m_plan = '{PH_DEC};
                  case (cls)
                     C_ALU:   begin m_plan.push_back(PH_EXE); m_plan.push_back(PH_WB); end
                     C_LOAD:  begin m_plan.push_back(PH_EXE); m_plan.push_back(PH_MEM); m_plan.push_back(PH_WB); end
                     C_STORE: begin m_plan.push_back(PH_EXE); m_plan.push_back(PH_MEM); end
                     C_JUMP:  m_plan.push_back(PH_EXE);
                     default: ;
                  endcase
               end
               cur       = m_plan[0];
               e_st      = cur;
               mem_ph    = (cur == PH_FETCH) || (cur == PH_MEM);
               step_done = !mem_ph || bus.mem_ready;
               tmo       = mem_ph && !bus.mem_ready && (m_wait == TIMEOUT - 1);
               e_mreq    = mem_ph;
               e_mwe     = (cur == PH_MEM) && (cls == C_STORE);
               e_irl     = (cur == PH_FETCH) && bus.mem_ready;
               e_pcl     = (cur == PH_EXE) && (cls == C_JUMP);
               e_alu     = (cur == PH_EXE) && (cls == C_ALU);
               e_rwe     = (cur == PH_WB);
               e_upd     = step_done && (cur != PH_FETCH) && (m_plan.size() == 1);
               if (tmo) begin
                  m_fault = 1'b1;
                  to_halt = 1'b1;
               end else if (step_done) begin
                  m_wait = 0;
                  void'(m_plan.pop_front());
                  if (e_upd) begin
                     if ((cur == PH_DEC && cls == C_HALT) || m_pend || bus.halt_req) begin
                        to_halt = 1'b1;
                     end else if (bus.step_mode) begin
                        m_where = WH_IDLE;
                     end else begin
                        m_plan = '{PH_FETCH, PH_DEC};
                     end
                  end
               end else begin
                  m_wait++;
               end
               if (to_halt) begin
                  m_where = WH_HALT;
                  m_pend  = 1'b0;
               end else if (bus.halt_req) begin
                  m_pend = 1'b1;
               end
            end
         endcase
      end
      exp_v = {e_mreq, e_mwe, e_irl, e_irl, e_pcl, e_alu, e_rwe, e_upd,
               e_run, e_hlt, e_flt, 3'(e_st)};
      checkOutput("outputs", 32'(out_vec), 32'(exp_v));
      if (count_rst) m_count = 0;
      checkOutput("count_out", 32'(count_out), 32'(m_count));
      if (!count_rst) m_count += int'(e_upd);
      if (bus.reg_we) reg_we_pulses++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b1;
      count_rst  = 1'b1;
      mem_rewind = 1'b1;
      for (int i = 0; i < 16; i++) prog[i] = 4'h0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      checkOutput("reset_outputs", 32'(out_vec), 32'h0);
      rst        = 1'b0;
      count_rst  = 1'b0;
      mem_rewind = 1'b0;
      tick(1);

      // Three ALU ops back to back, then a HALT opcode.
      prog[0] = 4'h3; prog[1] = 4'h3; prog[2] = 4'h3; prog[3] = 4'hF;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      rw_base = reg_we_pulses;
      tick(12);
      checkOutput("alu_count", 32'(count_out), 32'd3);
      checkOutput("alu_reg_we", 32'(reg_we_pulses - rw_base), 32'd3);
      checkOutput("alu_next_fetch", 32'(bus.state_out), 32'd1);
      tick(2);
      checkOutput("alu_halted", 32'(bus.halted), 32'd1);
      checkOutput("alu_halt_count", 32'(count_out), 32'd4);

      // Mixed stream NOP, LOAD, STORE, JUMP, HALT: 16 cycles to HALT.
      clearCounterAndProgram();
      prog[0] = 4'h0; prog[1] = 4'h8; prog[2] = 4'h9; prog[3] = 4'hA; prog[4] = 4'hF;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(15);
      checkOutput("mix_before_halt", 32'(bus.state_out), 32'd2);
      tick(1);
      checkOutput("mix_halted", 32'(bus.state_out), 32'd6);
      checkOutput("mix_count", 32'(count_out), 32'd5);

      // Fetch stall of 15 cycles survives; 16 cycles faults.
      clearCounterAndProgram();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(14);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("stall15_decode", 32'(bus.state_out), 32'd2);
      checkOutput("stall15_no_fault", 32'(bus.fault), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(16);
      checkOutput("stall16_still_fetch", 32'(bus.state_out), 32'd1);
      tick(1);
      checkOutput("stall16_fault", 32'(bus.fault), 32'd1);
      checkOutput("stall16_halted", 32'(bus.halted), 32'd1);
      checkOutput("stall16_count", 32'(count_out), 32'd1);

      // halt_req pulsed during a LOAD; start also clears the fault.
      clearCounterAndProgram();
      prog[0] = 4'h8;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("resume_fetch", 32'(bus.state_out), 32'd1);
      checkOutput("resume_fault_clear", 32'(bus.fault), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1);
      checkOutput("haltreq_wb", 32'(bus.state_out), 32'd5);
      tick(1);
      checkOutput("haltreq_halted", 32'(bus.state_out), 32'd6);
      checkOutput("haltreq_count", 32'(count_out), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick(1);
      checkOutput("start_and_halt_stay", 32'(bus.state_out), 32'd6);

      // Single-step mode: each start retires one ALU op and returns to IDLE.
      clearCounterAndProgram();
      prog[0] = 4'h3; prog[1] = 4'h5;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick(4);
      checkOutput("step_idle", 32'(bus.state_out), 32'd0);
      checkOutput("step_count1", 32'(count_out), 32'd1);
      tick(3);
      checkOutput("step_stays_idle", 32'(bus.state_out), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      tick(4);
      checkOutput("step_count2", 32'(count_out), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      tick(1);
      checkOutput("idle_haltreq_halted", 32'(bus.halted), 32'd1);
      checkOutput("idle_haltreq_count", 32'(count_out), 32'd2);

      // Reset while a LOAD waits in MEM.
      clearCounterAndProgram();
      prog[0] = 4'h8;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1);
      checkOutput("mem_state", 32'(bus.state_out), 32'd4);
      tick(1);
      rst = 1'b1;
      #1;
      checkOutput("rst_mid_outputs", 32'(out_vec), 32'h0);
      checkOutput("rst_mid_count", 32'(count_out), 32'd0);
      tick(2);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick(2);
      checkOutput("post_rst_idle", 32'(bus.state_out), 32'd0);
      checkOutput("post_rst_count", 32'(count_out), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Multi-cycle control FSM for the CPU core: sequences fetch/decode/execute/memory/writeback for each instruction.
- Drives PC, IR, ALU, register-file and memory strobes.
- Emits exactly one update_count pulse per retired instruction to instruction_count_register.
- Provides run/halt/single-step control and a memory-wait timeout fault.

Parameters:
OPCODE_W, 4, opcode field width
TIMEOUT, 16, max consecutive cycles waiting on mem_ready before fault (>=2)
STATE_W, 3, width of state_out

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces IDLE
start  input  1  launch/resume execution from IDLE or HALT
halt_req  input  1  request halt at next instruction boundary (sticky)
step_mode  input  1  1 = return to IDLE after each retire
opcode  input  OPCODE_W  current IR opcode, valid from DECODE onward
mem_ready  input  1  memory completes request this cycle
mem_req  output  1  memory request (FETCH, MEM)
mem_we  output  1  write enable (MEM with STORE)
ir_load  output  1  load IR (FETCH and mem_ready)
pc_inc  output  1  PC+1 (FETCH and mem_ready)
pc_load  output  1  PC <- jump target (EXECUTE, JUMP)
alu_en  output  1  ALU operation (EXECUTE, ALU class)
reg_we  output  1  register-file write (WB)
update_count  output  1  one-cycle retire pulse to instruction counter
running  output  1  state not in {IDLE, HALT}
halted  output  1  state == HALT
fault  output  1  sticky memory-timeout flag
state_out  output  STATE_W  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6.
- Registered: state, halt_pend, fault, wait_cnt. All strobes are combinational from state/opcode/mem_ready.
- Reset (async): state=IDLE, halt_pend=0, fault=0, wait_cnt=0. All strobes 0, running=0, halted=0, state_out=0.
- Opcode classes:
  - 0x0 NOP
  - 0x1-0x7 ALU
  - 0x8 LOAD
  - 0x9 STORE
  - 0xA JUMP
  - 0xF HALT
  - others treated as NOP.
- IDLE: start=1 -> FETCH.
- FETCH: mem_req=1.
  - mem_ready=1 -> ir_load=1, pc_inc=1, go to DECODE.
  - Otherwise stay.
- DECODE (1 cycle):
  - NOP -> retire.
  - HALT -> update_count=1, go to HALT.
  - Else -> EXECUTE.
- EXECUTE (1 cycle):
  - ALU -> alu_en=1, go to WB.
  - LOAD/STORE -> MEM.
  - JUMP -> pc_load=1, retire.
- MEM: mem_req=1, mem_we=(STORE).
  - On mem_ready: LOAD -> WB; STORE -> retire.
- WB: reg_we=1, retire.
- Retire: update_count=1 in that same cycle; next state chosen by priority:
  - halt_pend or halt_req -> HALT
  - step_mode -> IDLE
  - else -> FETCH
- Cycle latencies with zero-wait memory:
  - NOP 2
  - JUMP 3
  - ALU 4
  - STORE 4
  - LOAD 5
  - HALT 2
- halt_req: sets halt_pend whenever asserted while running. halt_pend clears on entry to HALT.
- halt_req in IDLE: go to HALT directly, no update_count.
- HALT: start=1 -> FETCH, clears fault, halted drops next cycle. start and halt_req both high in HALT: stay in HALT.
- Timeout:
  - wait_cnt clears on every entry to FETCH/MEM.
  - It increments each FETCH/MEM cycle with mem_ready=0.
  - If mem_ready=0 while wait_cnt==TIMEOUT-1: fault=1, go to HALT, no update_count.
  - mem_ready in that same cycle wins; no fault.
- Reset mid-instruction: immediate IDLE; the instruction is not retired and update_count is not pulsed.
- update_count is never high for two consecutive cycles.

Decomposition:
- Package cpu_ctrl_pkg: state encodings, opcode constants/class codes, TIMEOUT default.
- Sub-module opcode_class_decode (combinational): opcode -> {is_nop, is_alu, is_load, is_store, is_jump, is_halt}.
- FSM, wait counter and flags stay in instr_sequencer.
- Bench instantiates instr_sequencer together with instruction_count_register (update_count wired through).

Test Plan:
- Run 3 ALU ops (opcode 0x3), mem_ready=1: update_count pulses every 4 cycles; count_out 0->3 after 12 cycles post-start; reg_we pulses 3 times.
- Mixed stream NOP, LOAD, STORE, JUMP, HALT with mem_ready=1: exactly 5 update_count pulses over 2+5+4+3+2=16 cycles. halted=1 afterwards; count_out=5.
- FETCH with mem_ready held 0 for 15 cycles, then 1: no fault, DECODE next. Held 0 for 16 cycles: fault=1, HALT, count unchanged.
- halt_req pulsed 1 cycle mid-LOAD: LOAD completes (update_count once), then HALT. start clears fault/halted and resumes at FETCH.
- step_mode=1, ALU op: retire -> IDLE; state_out=0 until next start; count increments by 1 per start.
- Reset asserted in MEM state: state_out=0 at once, all strobes 0, no update_count pulse, count_out unchanged.
